// File: rtl/ransac_inlier_engine.sv
// Buffers packed (x,y) points in a local RAM and scores a line model a*x+b*y+c against them,
// counting points whose |residual| is within threshold and remembering the best model tag.
module ransac_inlier_engine #(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned COEF_W  = 16,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                       CLOCK_50,
    input  logic                       KEY,
    input  logic [2*COORD_W-1:0]       data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       load_clear,
    input  logic [COEF_W-1:0]          model_a,
    input  logic [COEF_W-1:0]          model_b,
    input  logic [COORD_W+COEF_W:0]    model_c,
    input  logic [COORD_W+COEF_W:0]    threshold,
    input  logic [TAG_W-1:0]           model_tag,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     point_count,
    output logic [$clog2(DEPTH):0]     inlier_count,
    output logic [$clog2(DEPTH):0]     best_count,
    output logic [TAG_W-1:0]           best_tag,
    output logic                       overflow
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned P_W = COORD_W + COEF_W;
    localparam int unsigned C_W = P_W + 1;
    localparam int unsigned R_W = P_W + 2;

    typedef enum logic [1:0] {StIdle, StEval, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic                      ready_q;
    logic [AW:0]               count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [AW:0]               n_q, n_d;
    logic signed [COEF_W-1:0]  a_q, a_d, b_q, b_d;
    logic signed [C_W-1:0]     c_q, c_d;
    logic [C_W-1:0]            thr_q, thr_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic                      v1_q, v1_d, v2_q, v2_d;
    logic signed [P_W-1:0]     pa_q, pa_d, pb_q, pb_d;
    logic [AW:0]               acc_q, acc_d;
    logic [AW:0]               inlier_q, inlier_d;
    logic [AW:0]               best_q, best_d;
    logic [TAG_W-1:0]          best_tag_q, best_tag_d;

    logic [2*COORD_W-1:0]      mem [DEPTH];
    logic [2*COORD_W-1:0]      rd_q;
    logic                      wr_en;
    logic                      full;
    logic signed [COORD_W-1:0] px, py;
    logic signed [R_W-1:0]     resid;
    logic [R_W-1:0]            mag;
    logic                      hit;

    assign full     = (count_q >= (AW+1)'(DEPTH));
    assign in_ready = ready_q && (state_q == StIdle) && !full;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

    assign point_count  = count_q;
    assign inlier_count = inlier_q;
    assign best_count   = best_q;
    assign best_tag     = best_tag_q;
    assign overflow     = ovf_q;

    assign px = rd_q[2*COORD_W-1:COORD_W];
    assign py = rd_q[COORD_W-1:0];

    // Residual is two bits wider than a product so the sum of two extreme products cannot wrap.
    assign resid = R_W'(pa_q) + R_W'(pb_q) + R_W'(c_q);
    assign mag   = resid[R_W-1] ? R_W'(-resid) : R_W'(resid);
    assign hit   = (mag <= {1'b0, thr_q});

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        addr_d     = addr_q;
        n_d        = n_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        thr_d      = thr_q;
        tag_d      = tag_q;
        inlier_d   = inlier_q;
        best_d     = best_q;
        best_tag_d = best_tag_q;
        wr_en      = 1'b0;
        v1_d       = 1'b0;
        v2_d       = v1_q;
        pa_d       = P_W'(a_q) * P_W'(px);
        pb_d       = P_W'(b_q) * P_W'(py);
        acc_d      = (v2_q && hit) ? acc_q + 1'b1 : acc_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d    = model_a;
                    b_d    = model_b;
                    c_d    = model_c;
                    thr_d  = threshold;
                    tag_d  = model_tag;
                    n_d    = count_q;
                    addr_d = '0;
                    acc_d  = '0;
                    if (count_q == '0) begin
                        inlier_d = '0;
                        state_d  = StDone;
                    end else begin
                        state_d  = StEval;
                    end
                end else if (load_clear) begin
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    best_d     = '0;
                    best_tag_d = '0;
                end else if (in_valid) begin
                    if (in_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end else if (full) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StEval: begin
                v1_d   = 1'b1;
                addr_d = addr_q + 1'b1;
                if ({1'b0, addr_q} == n_q - 1'b1) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!v1_q && !v2_q) begin
                    state_d  = StDone;
                    inlier_d = acc_q;
                    // Strict compare: an equal score keeps the earlier tag.
                    if (acc_q > best_q) begin
                        best_d     = acc_q;
                        best_tag_d = tag_q;
                    end
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            addr_q     <= '0;
            n_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            thr_q      <= '0;
            tag_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            pa_q       <= '0;
            pb_q       <= '0;
            acc_q      <= '0;
            inlier_q   <= '0;
            best_q     <= '0;
            best_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            thr_q      <= thr_d;
            tag_q      <= tag_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            pa_q       <= pa_d;
            pb_q       <= pb_d;
            acc_q      <= acc_d;
            inlier_q   <= inlier_d;
            best_q     <= best_d;
            best_tag_q <= best_tag_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[count_q[AW-1:0]] <= data_in;
        end
        rd_q <= mem[addr_q];
    end

endmodule

// File: tb/tb_ransac_inlier_engine.sv
// Directed bench for ransac_inlier_engine with a 4-entry point RAM and 16-bit coordinates.
module tb_ransac_inlier_engine;

    logic        CLOCK_50;
    logic        KEY;
    logic [31:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        load_clear;
    logic [15:0] model_a, model_b;
    logic [32:0] model_c, threshold;
    logic [7:0]  model_tag;
    logic        start;
    logic        busy, done;
    logic [2:0]  point_count, inlier_count, best_count;
    logic [7:0]  best_tag;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    ransac_inlier_engine #(
        .COORD_W(16),
        .COEF_W (16),
        .DEPTH  (4),
        .TAG_W  (8)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .KEY         (KEY),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .load_clear  (load_clear),
        .model_a     (model_a),
        .model_b     (model_b),
        .model_c     (model_c),
        .threshold   (threshold),
        .model_tag   (model_tag),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .point_count (point_count),
        .inlier_count(inlier_count),
        .best_count  (best_count),
        .best_tag    (best_tag),
        .overflow    (overflow)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // All stimulus helpers start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y);
        data_in  = {x, y};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
    endtask

    task automatic load4();
        push(16'd0, 16'd0);
        push(16'd1, 16'd1);
        push(16'd2, 16'd2);
        push(16'd3, 16'd10);
    endtask

    task automatic set_model(input logic [15:0] a, input logic [15:0] b, input logic [32:0] c,
                             input logic [32:0] thr, input logic [7:0] tag);
        model_a   = a;
        model_b   = b;
        model_c   = c;
        threshold = thr;
        model_tag = tag;
    endtask

    // Pulses start, counts edges until done (bounded), then steps past the done cycle.
    task automatic run_model(input logic [15:0] a, input logic [15:0] b, input logic [32:0] c,
                             input logic [32:0] thr, input logic [7:0] tag,
                             output int edges, output int busy_n,
                             output logic busy_at_done, output logic done_after);
        set_model(a, b, c, thr, tag);
        start = 1'b1;
        tick();
        start  = 1'b0;
        edges  = 0;
        busy_n = 0;
        while (!done && edges < 40) begin
            if (busy) busy_n++;
            tick();
            edges++;
        end
        busy_at_done = busy;
        set_model(16'h1234, 16'h4321, 33'h1_0000_0000, 33'd0, 8'hEE);
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if ({busy, done, overflow} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); end
        n_cmp++; if ({point_count, inlier_count, best_count, best_tag} !== 17'd0) begin n_err++; $display("FAIL reset_counts: got %h want 0", {point_count, inlier_count, best_count, best_tag}); end
        @(posedge CLOCK_50);
        #2 KEY = 1'b1;
        @(posedge CLOCK_50);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int e, bn;
        logic bd, da;
        clear();
        load4();
        n_cmp++; if (point_count !== 3'd4) begin n_err++; $display("FAIL load_count: got %0d want 4", point_count); end
        run_model(16'd1, 16'hFFFF, 33'd0, 33'd0, 8'd5, e, bn, bd, da);
        n_cmp++; if (e !== 7) begin n_err++; $display("FAIL basic_latency: got %0d want 7", e); end
        n_cmp++; if (bn !== 7) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 7", bn); end
        n_cmp++; if (bd !== 1'b1) begin n_err++; $display("FAIL basic_busy_at_done: got %0b want 1", bd); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %0b want 0", da); end
        n_cmp++; if (inlier_count !== 3'd3) begin n_err++; $display("FAIL basic_inliers: got %0d want 3", inlier_count); end
        n_cmp++; if (best_count !== 3'd3) begin n_err++; $display("FAIL basic_best_count: got %0d want 3", best_count); end
        n_cmp++; if (best_tag !== 8'd5) begin n_err++; $display("FAIL basic_best_tag: got %0d want 5", best_tag); end
    endtask

    task automatic test_rerun_tie();
        int e, bn;
        logic bd, da;
        run_model(16'd1, 16'hFFFF, 33'd0, 33'd7, 8'd9, e, bn, bd, da);
        n_cmp++; if (inlier_count !== 3'd4) begin n_err++; $display("FAIL rerun_inliers: got %0d want 4", inlier_count); end
        n_cmp++; if (best_tag !== 8'd9) begin n_err++; $display("FAIL rerun_best_tag: got %0d want 9", best_tag); end
        run_model(16'd1, 16'hFFFF, 33'd0, 33'd8, 8'd2, e, bn, bd, da);
        n_cmp++; if (inlier_count !== 3'd4) begin n_err++; $display("FAIL tie_inliers: got %0d want 4", inlier_count); end
        n_cmp++; if (best_count !== 3'd4) begin n_err++; $display("FAIL tie_best_count: got %0d want 4", best_count); end
        n_cmp++; if (best_tag !== 8'd9) begin n_err++; $display("FAIL tie_best_tag: got %0d want 9", best_tag); end
    endtask

    task automatic test_overflow();
        int e, bn;
        logic bd, da;
        clear();
        data_in  = {16'd1, 16'd1};
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        n_cmp++; if (point_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", point_count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_overflow: got %0b want 1", overflow); end
        run_model(16'd1, 16'hFFFF, 33'd0, 33'd0, 8'd3, e, bn, bd, da);
        n_cmp++; if (best_count !== 3'd4) begin n_err++; $display("FAIL full_best_count: got %0d want 4", best_count); end
        clear();
        n_cmp++; if (point_count !== 3'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", point_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clear_overflow: got %0b want 0", overflow); end
        n_cmp++; if ({best_count, best_tag} !== 11'd0) begin n_err++; $display("FAIL clear_best: got %h want 0", {best_count, best_tag}); end
    endtask

    task automatic test_extremes();
        int e, bn;
        logic bd, da;
        clear();
        push(16'h8000, 16'h8000);
        run_model(16'h8000, 16'h8000, 33'd0, 33'h0_8000_0000, 8'd1, e, bn, bd, da);
        n_cmp++; if (inlier_count !== 3'd1) begin n_err++; $display("FAIL ext_thr_2p31: got %0d want 1", inlier_count); end
        run_model(16'h8000, 16'h8000, 33'd0, 33'h0_7FFF_FFFF, 8'd2, e, bn, bd, da);
        n_cmp++; if (inlier_count !== 3'd0) begin n_err++; $display("FAIL ext_thr_2p31m1: got %0d want 0", inlier_count); end
    endtask

    task automatic test_edge_cases();
        int e, bn, dones;
        logic bd, da;
        clear();
        run_model(16'd1, 16'hFFFF, 33'd0, 33'd0, 8'd4, e, bn, bd, da);
        n_cmp++; if (e !== 0) begin n_err++; $display("FAIL empty_latency: got %0d want 0", e); end
        n_cmp++; if (inlier_count !== 3'd0) begin n_err++; $display("FAIL empty_inliers: got %0d want 0", inlier_count); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse: got %0b want 0", da); end
        data_in  = {16'd7, 16'd7};
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        n_cmp++; if (point_count !== 3'd0) begin n_err++; $display("FAIL start_vs_write_count: got %0d want 0", point_count); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL start_vs_write_done: got %0b want 1", done); end
        tick();
        push(16'd0, 16'd0);
        push(16'd5, 16'd5);
        set_model(16'd1, 16'hFFFF, 33'd0, 33'd0, 8'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            tick();
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL start_busy_dones: got %0d want 1", dones); end
        n_cmp++; if (inlier_count !== 3'd2) begin n_err++; $display("FAIL start_busy_inliers: got %0d want 2", inlier_count); end
    endtask

    task automatic test_reset_mid_eval();
        int e, bn;
        logic bd, da;
        clear();
        load4();
        set_model(16'd1, 16'hFFFF, 33'd0, 33'd0, 8'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(posedge CLOCK_50);
        #1 KEY = 1'b0;
        #1;
        n_cmp++; if ({busy, done, overflow, in_ready} !== 4'b0000) begin n_err++; $display("FAIL midreset_flags: got %b want 0000", {busy, done, overflow, in_ready}); end
        n_cmp++; if ({point_count, inlier_count, best_count, best_tag} !== 17'd0) begin n_err++; $display("FAIL midreset_counts: got %h want 0", {point_count, inlier_count, best_count, best_tag}); end
        #1 KEY = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready: got %0b want 1", in_ready); end
        load4();
        run_model(16'd1, 16'hFFFF, 33'd0, 33'd0, 8'd7, e, bn, bd, da);
        n_cmp++; if (e !== 7) begin n_err++; $display("FAIL postreset_latency: got %0d want 7", e); end
        n_cmp++; if (inlier_count !== 3'd3) begin n_err++; $display("FAIL postreset_inliers: got %0d want 3", inlier_count); end
        n_cmp++; if (best_tag !== 8'd7) begin n_err++; $display("FAIL postreset_best_tag: got %0d want 7", best_tag); end
    endtask

    initial begin
        KEY        = 1'b0;
        data_in    = '0;
        in_valid   = 1'b0;
        load_clear = 1'b0;
        start      = 1'b0;
        set_model(16'd0, 16'd0, 33'd0, 33'd0, 8'd0);
        test_reset();
        test_basic();
        test_rerun_tie();
        test_overflow();
        test_extremes();
        test_edge_cases();
        test_reset_mid_eval();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ransac_inlier_engine.md
Name: ransac_inlier_engine

Overview:
- Parametrised successor to the single-word RANSAC data path.
- Buffers a stream of packed (x,y) points from the NIOS-side bus into an internal point RAM.
- On a start pulse, scores one line model a*x + b*y + c against every stored point using a pipelined datapath, and counts inliers (|residual| <= threshold).
- Tracks the best-scoring model tag across runs, so software can iterate hypotheses without re-sending points.

Parameters:
- COORD_W, 16, signed bit width of x and of y; input word is 2*COORD_W bits.
- COEF_W, 16, signed bit width of model_a, model_b; model_c is COORD_W+COEF_W+1 bits signed.
- DEPTH, 64, point RAM capacity (>=2); AW = clog2(DEPTH) is a derived localparam, not overridable.
- TAG_W, 8, width of model_tag / best_tag.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- KEY  in  1  asynchronous active-low reset.
- data_in  in  2*COORD_W  point word {x[COORD_W-1:0], y[COORD_W-1:0]}, two's complement.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  engine can accept a point.
- load_clear  in  1  pulse: empty point RAM, clear overflow, best_count, best_tag.
- model_a, model_b  in  COEF_W  line coefficients, signed.
- model_c  in  COORD_W+COEF_W+1  offset, signed.
- threshold  in  COORD_W+COEF_W+1  unsigned inlier bound.
- model_tag  in  TAG_W  caller's identifier for the model.
- start  in  1  pulse: begin evaluation.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle completion pulse.
- point_count  out  AW+1  points stored.
- inlier_count  out  AW+1  result of last run; held until next done.
- best_count  out  AW+1  highest inlier_count since load_clear.
- best_tag  out  TAG_W  model_tag of that run.
- overflow  out  1  sticky: write attempted while full.

Behaviour:
- Reset (KEY=0, async): every output 0, state IDLE, RAM contents don't-care. in_ready = 0 during reset, then 1 at the first edge after release.
- in_ready = (state==IDLE) & (point_count<DEPTH).
- Store on in_valid & in_ready: write RAM[point_count], then point_count+1.
- in_valid while full: word dropped, overflow set.
- in_valid while busy: word dropped, overflow unchanged.
- load_clear in the same cycle as a write: clear wins, write dropped.
- load_clear while busy: ignored.
- start is sampled only in IDLE; ignored while busy. start and in_valid in the same cycle: start wins, write dropped.
- On the start edge, latch model_a/b/c, threshold, model_tag and N = point_count. Later input changes do not affect the run.
- States:
  - IDLE -> EVAL on start with N>0.
  - IDLE -> DONE on start with N=0; inlier_count = 0; done at the next edge.
  - EVAL: issue read address 0..N-1, one per cycle -> DRAIN after the last address.
  - DRAIN: wait for pipeline empty -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- Pipeline:
  - edge k+1: RAM registered read of point k.
  - edge k+2: products a*x and b*y registered, each COORD_W+COEF_W bits signed.
  - edge k+3: r = pa + pb + c, computed in COORD_W+COEF_W+2 bits signed with all operands sign-extended, so no overflow is possible. |r| compared unsigned <= threshold; the accumulator increments on a match.
- Latency: done is high during the cycle after edge N+3, counted from the start-sampling edge (edge 0). busy is high from edge 0 until done falls.
- At done:
  - inlier_count <= accumulator.
  - If accumulator > best_count (strict), update best_count and best_tag; ties keep the earlier tag.
- Point RAM is preserved across runs; only load_clear or reset empties it.

Test Plan:
- Load (0,0),(1,1),(2,2),(3,10); a=1, b=-1, c=0, thr=0, tag=5, start -> done exactly 7 edges after start; inlier_count=3; best_count=3, best_tag=5; busy high 7 cycles.
- Same points, rerun with thr=7, tag=9 -> 4 inliers, best_tag=9. Then thr=8, tag=2 -> 4 inliers (tie), best_tag remains 9.
- DEPTH=4: present 5 words with in_valid held -> point_count=4, in_ready=0, overflow=1. load_clear -> point_count=0, overflow=0, best_count=0.
- Width extremes: point (-32768,-32768), a=b=-32768, c=0, so r=2^31. thr=2^31 -> 1 inlier; thr=2^31-1 -> 0 inliers; no sign wrap.
- Edge cases: start with 0 points -> done next edge, inlier_count=0. start and in_valid in the same cycle -> word dropped. start while busy -> ignored, one done only.
- Reset: KEY low mid-EVAL (N=4, after 2 edges) -> all outputs 0 immediately. After release, in_ready=1 and a fresh load/run gives the correct count.
